exu_muldiv: RTL and testbench

- Next-generation execute unit with an XLEN-parametrised integer ALU and the RV32M/RV64M multiply/divide ops.
- Adds valid/ready handshakes on both sides and multi-cycle operation:
  - pipelined-latency multiplier (configurable latency);
  - iterative radix-2 divider.
- Sits between the ID/EX register and the MEM stage.
- Operands arrive already forwarded/selected. The block holds one operation in flight and stalls upstream via in_ready.

---
 rtl/exu_muldiv.sv | 182 ++++++++++++++++++
 tb/tb_exu_muldiv.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exu_muldiv.sv
// rtl/exu_muldiv.sv - execute unit: XLEN ALU plus multi-cycle RV32M/RV64M multiply/divide
module exu_muldiv #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int SH_W    = $clog2(XLEN);
    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  mul_res_q, quo_q, rem_q, dvs_q;
    logic             neg_q_q, neg_r_q, is_rem_q;

    logic            accept, fire, is_mul, is_div, div_signed, div_zero, div_ovf, div_early;
    logic            load_imm, load_mul, load_div, last_step;
    logic [XLEN-1:0] imm_res, div_res, a_mag, b_mag, quo_nx, rem_nx;
    logic [XLEN:0]   rem_sh, diff;
    logic            mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;

    assign fire       = out_valid && out_ready;
    assign accept     = in_valid && in_ready && !flush;
    assign is_mul     = (in_op[4:2] == 3'b100);
    assign is_div     = (in_op[4:2] == 3'b101);
    assign div_signed = is_div && !in_op[0];
    assign div_zero   = (in_src2 == '0);
    assign div_ovf    = div_signed && (in_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_src2 == '1);
    assign div_early  = div_zero || div_ovf;
    assign a_mag      = (div_signed && in_src1[XLEN-1]) ? -in_src1 : in_src1;
    assign b_mag      = (div_signed && in_src2[XLEN-1]) ? -in_src2 : in_src2;
    // Results available at accept: ALU ops, divide early-outs, and single-cycle multiplies.
    assign load_imm   = accept && ((!is_mul && !(is_div && !div_early)) || (is_mul && (MUL_LAT == 1)));
    assign last_step  = (cnt_q == CNT_W'(1));
    assign load_mul   = (state_q == S_MUL) && last_step && !flush;
    assign load_div   = (state_q == S_DIV) && last_step && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: DONE behaves like IDLE for accepting, so a fire and a new accept can share a cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (load_imm)    state_d = S_DONE;
                    else if (is_mul) state_d = S_MUL;
                    else             state_d = S_DIV;
                end else if (fire) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL:   if (last_step) state_d = S_DONE;
            S_DIV:   if (last_step) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Handshake and status outputs derived from the current state.
    always_comb begin
        out_valid = (state_q == S_DONE);
        in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
        busy      = (state_q != S_IDLE) || out_valid;
    end

    // Full 2*XLEN product; sign-extending to 2*XLEN makes the modular product exact.
    always_comb begin
        mul_sa = (in_op[1:0] != 2'b11);
        mul_sb = !in_op[1];
        mul_a  = {{XLEN{mul_sa & in_src1[XLEN-1]}}, in_src1};
        mul_b  = {{XLEN{mul_sb & in_src2[XLEN-1]}}, in_src2};
        prod   = mul_a * mul_b;
    end

    // Immediate result select: ALU ops, multiply halves, divide early-out values.
    always_comb begin
        imm_res = in_src1 + in_src2;
        case (in_op)
            5'd1:  imm_res = in_src1 - in_src2;
            5'd2:  imm_res = in_src1 & in_src2;
            5'd3:  imm_res = in_src1 | in_src2;
            5'd4:  imm_res = in_src1 ^ in_src2;
            5'd5:  imm_res = in_src1 << in_src2[SH_W-1:0];
            5'd6:  imm_res = in_src1 >> in_src2[SH_W-1:0];
            5'd7:  imm_res = $unsigned($signed(in_src1) >>> in_src2[SH_W-1:0]);
            5'd8:  imm_res = {{(XLEN-1){1'b0}}, $signed(in_src1) < $signed(in_src2)};
            5'd9:  imm_res = {{(XLEN-1){1'b0}}, in_src1 < in_src2};
            5'd10: imm_res = in_src2;
            5'd11: imm_res = in_src1;
            5'd16: imm_res = prod[XLEN-1:0];
            5'd17, 5'd18, 5'd19: imm_res = prod[2*XLEN-1:XLEN];
            5'd20, 5'd21, 5'd22, 5'd23: begin
                if (div_zero) imm_res = in_op[1] ? in_src1 : '1;
                else          imm_res = in_op[1] ? '0 : in_src1;
            end
            default: imm_res = in_src1 + in_src2;
        endcase
    end

    // One restoring divide step; the final step also applies the result sign.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        quo_nx = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_nx = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        if (is_rem_q) div_res = neg_r_q ? -rem_nx : rem_nx;
        else          div_res = neg_q_q ? -quo_nx : quo_nx;
    end

    // Datapath: operand capture, iteration, and the held output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            tag_q      <= '0;
            mul_res_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            is_rem_q   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else begin
            if (accept) begin
                tag_q     <= in_tag;
                mul_res_q <= imm_res;
                quo_q     <= a_mag;
                rem_q     <= '0;
                dvs_q     <= b_mag;
                neg_q_q   <= div_signed && (in_src1[XLEN-1] ^ in_src2[XLEN-1]);
                neg_r_q   <= div_signed && in_src1[XLEN-1];
                is_rem_q  <= in_op[1];
                if (load_imm)    cnt_q <= '0;
                else if (is_mul) cnt_q <= CNT_W'(MUL_LAT - 1);
                else             cnt_q <= CNT_W'(XLEN);
            end else if ((state_q == S_MUL) || (state_q == S_DIV)) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (state_q == S_DIV) begin
                    quo_q <= quo_nx;
                    rem_q <= rem_nx;
                end
            end
            if (load_imm) begin
                out_result <= imm_res;
                out_tag    <= in_tag;
            end else if (load_mul) begin
                out_result <= mul_res_q;
                out_tag    <= tag_q;
            end else if (load_div) begin
                out_result <= div_res;
                out_tag    <= tag_q;
            end
        end
    end
endmodule

// File: tb/tb_exu_muldiv.sv
// tb/tb_exu_muldiv.sv - directed table-driven bench for exu_muldiv
module tb_exu_muldiv;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]  in_op, in_tag, out_tag;
    logic [31:0] in_src1, in_src2, out_result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    exu_muldiv #(.XLEN(32), .MUL_LAT(2), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.tag = tag; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        bit  seen;
        bit  between_ok;
        @(posedge clk); #1;
        drive(v.op, v.a, v.b, v.tag);
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0; seen = 1'b0; between_ok = 1'b1;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
            else if (in_ready) between_ok = 1'b0;
        end
        if (!seen) n = 999;
        chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
        chk($sformatf("v%0d_result", idx), out_result, v.exp);
        chk($sformatf("v%0d_tag", idx), 32'(out_tag), 32'(v.tag));
        if (v.lat > 1) chk($sformatf("v%0d_stall", idx), 32'(between_ok), 32'd1);
    endtask

    task automatic watch_none(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    logic [4:0]  s_op[4]  = '{5'd0, 5'd1, 5'd7, 5'd9};
    logic [31:0] s_a[4]   = '{32'd7, 32'd3, 32'h80000000, 32'd1};
    logic [31:0] s_b[4]   = '{32'd5, 32'd5, 32'd4, 32'd1};
    logic [31:0] s_exp[4] = '{32'd12, 32'hFFFFFFFE, 32'hF8000000, 32'd0};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_src1 = '0; in_src2 = '0; in_tag = '0; out_ready = 1'b1;

        add(5'd0,  32'd7,        32'd5,        5'd1,  32'd12,        1);
        add(5'd1,  32'd3,        32'd5,        5'd2,  32'hFFFFFFFE,  1);
        add(5'd2,  32'h0000F0F0, 32'h0000FF00, 5'd3,  32'h0000F000,  1);
        add(5'd3,  32'h0000F0F0, 32'h0000FF00, 5'd4,  32'h0000FFF0,  1);
        add(5'd4,  32'h0000F0F0, 32'h0000FF00, 5'd5,  32'h00000FF0,  1);
        add(5'd5,  32'd1,        32'd35,       5'd6,  32'd8,         1);
        add(5'd6,  32'h80000000, 32'd31,       5'd7,  32'd1,         1);
        add(5'd7,  32'h80000000, 32'd4,        5'd8,  32'hF8000000,  1);
        add(5'd8,  32'hFFFFFFFF, 32'd1,        5'd9,  32'd1,         1);
        add(5'd9,  32'hFFFFFFFF, 32'd1,        5'd10, 32'd0,         1);
        add(5'd10, 32'd11,       32'd22,       5'd11, 32'd22,        1);
        add(5'd11, 32'd11,       32'd22,       5'd12, 32'd11,        1);
        add(5'd12, 32'd2,        32'd3,        5'd13, 32'd5,         1);
        add(5'd16, 32'hFFFFFFFF, 32'd2,        5'd14, 32'hFFFFFFFE,  2);
        add(5'd17, 32'hFFFFFFFF, 32'd2,        5'd15, 32'hFFFFFFFF,  2);
        add(5'd19, 32'hFFFFFFFF, 32'd2,        5'd16, 32'h00000001,  2);
        add(5'd18, 32'hFFFFFFFF, 32'd2,        5'd17, 32'hFFFFFFFF,  2);
        add(5'd20, 32'hFFFFFFF9, 32'd2,        5'd18, 32'hFFFFFFFD,  33);
        add(5'd22, 32'hFFFFFFF9, 32'd2,        5'd19, 32'hFFFFFFFF,  33);
        add(5'd21, 32'd100,      32'd7,        5'd20, 32'd14,        33);
        add(5'd23, 32'd100,      32'd7,        5'd21, 32'd2,         33);
        add(5'd20, 32'd7,        32'hFFFFFFFE, 5'd22, 32'hFFFFFFFD,  33);
        add(5'd22, 32'd7,        32'hFFFFFFFE, 5'd23, 32'd1,         33);
        add(5'd21, 32'h80000000, 32'hFFFFFFFF, 5'd24, 32'd0,         33);
        add(5'd20, 32'd5,        32'd0,        5'd25, 32'hFFFFFFFF,  1);
        add(5'd23, 32'd5,        32'd0,        5'd26, 32'd5,         1);
        add(5'd20, 32'h80000000, 32'hFFFFFFFF, 5'd27, 32'h80000000,  1);
        add(5'd22, 32'h80000000, 32'hFFFFFFFF, 5'd28, 32'd0,         1);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // back-to-back ALU stream
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(s_op[i], s_a[i], s_b[i], 5'(i + 1));
            else in_valid = 1'b0;
            @(negedge clk);
            if (i < 4) chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
            if (i > 0) begin
                chk($sformatf("stream%0d_out_valid", i - 1), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d_result", i - 1), out_result, s_exp[i - 1]);
                chk($sformatf("stream%0d_tag", i - 1), 32'(out_tag), 32'(i));
            end
            @(posedge clk); #1;
        end

        // table vectors
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(5'd0, 32'd1, 32'd1, 5'd9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_result", k), out_result, 32'd2);
            chk($sformatf("bp%0d_tag", k), 32'(out_tag), 32'd9);
            chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(5'd0, 32'd10, 32'd20, 5'd10);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_result", out_result, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_out_valid", 32'(out_valid), 32'd1);
        chk("bp_next_result", out_result, 32'd30);
        chk("bp_next_tag", 32'(out_tag), 32'd10);

        // flush mid-divide with a competing offer
        @(posedge clk); #1;
        drive(5'd21, 32'd100, 32'd7, 5'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        drive(5'd0, 32'd1, 32'd2, 5'd4);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        watch_none("flush_no_result");

        // reset mid-divide with a competing offer
        @(posedge clk); #1;
        drive(5'd20, 32'hFFFFFFF9, 32'd2, 5'd5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        drive(5'd0, 32'd1, 32'd2, 5'd6);
        @(negedge clk);
        chk("rst2_in_ready_during", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_out_result", out_result, 32'd0);
        chk("rst2_out_tag", 32'(out_tag), 32'd0);
        watch_none("rst2_no_result");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
